// File: rtl/fetch.sv
// Instruction fetch stage: drives the instruction-memory request, fills the IF/ID register,
// absorbs one word in a skid buffer under decode back-pressure, and handles branch redirects.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [63:0] ifid_reg,
   output logic        ifid_valid
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [63:0] skid_q, skid_d;
   logic [63:0] ifid_q, ifid_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        can_accept;
   logic [31:0] redirect_target;
   logic [31:0] pc_next;

   assign can_accept      = !ifid_valid_q || !stall;
   assign redirect_target = redirect_pc & ~32'h0000_0003;
   assign pc_next         = pc_q + PC_STEP;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         drop_addr_q  <= RESET_PC;
         skid_q       <= '0;
         ifid_q       <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_addr_q  <= drop_addr_d;
         skid_q       <= skid_d;
         ifid_q       <= ifid_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_addr_d  = drop_addr_q;
      skid_d       = skid_q;
      ifid_d       = ifid_q;
      ifid_valid_d = ifid_valid_q;
      // A consumed instruction empties IF/ID unless something new is loaded below.
      if (ifid_valid_q && !stall) ifid_valid_d = 1'b0;
      unique case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (redirect_valid) begin
               pc_d         = redirect_target;
               ifid_valid_d = 1'b0;
               if (!imem_ack) begin
                  drop_addr_d = pc_q;
                  state_d     = DROP;
               end
            end else if (imem_ack) begin
               pc_d = pc_next;
               if (can_accept) begin
                  ifid_d       = {pc_q, imem_rdata};
                  ifid_valid_d = 1'b1;
               end else begin
                  skid_d  = {pc_q, imem_rdata};
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_d         = redirect_target;
               ifid_valid_d = 1'b0;
               skid_d       = '0;
               state_d      = FETCH;
            end else if (!stall) begin
               ifid_d       = skid_q;
               ifid_valid_d = 1'b1;
               state_d      = FETCH;
            end
         end
         DROP: begin
            // The stale request stays on the bus at its original address until acknowledged.
            if (redirect_valid) begin
               pc_d         = redirect_target;
               ifid_valid_d = 1'b0;
            end else if (imem_ack) begin
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_req   = (state_q == FETCH) || (state_q == DROP);
   assign imem_addr  = (state_q == DROP) ? drop_addr_q : pc_q;
   assign ifid_reg   = ifid_q;
   assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch.sv
// Directed-vector bench for fetch: table of per-cycle inputs with expected outputs,
// followed by a hand-written reset-during-request sequence.
module tb_fetch;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [63:0] ifid_reg;
   logic        ifid_valid;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ack;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [63:0] exp_ifid;
   } vec_t;

   vec_t vecs[$];

   fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ifid_reg       (ifid_reg),
      .ifid_valid     (ifid_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [63:0] ifid);
      chk({tag, ".imem_req"},   64'(imem_req),   64'(req));
      chk({tag, ".imem_addr"},  64'(imem_addr),  64'(addr));
      chk({tag, ".ifid_valid"}, 64'(ifid_valid), 64'(valid));
      chk({tag, ".ifid_reg"},   ifid_reg,        ifid);
   endtask

   task automatic add(input logic s, input logic r, input logic [31:0] rpc, input logic a,
                      input logic [31:0] rd, input logic er, input logic [31:0] ea,
                      input logic ev, input logic [63:0] ei);
      vec_t v;
      v.stall = s; v.redir = r; v.rpc = rpc; v.ack = a; v.rdata = rd;
      v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_ifid = ei;
      vecs.push_back(v);
   endtask

   initial begin
      //   stall redir rpc           ack rdata         req addr          valid ifid
      add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0000, 0, 64'h0);
      add(0, 0, 32'h0,         1, 32'h0,         1, 32'h0000_0004, 1, {32'h0, 32'h0});
      add(0, 0, 32'h0,         1, 32'h4,         1, 32'h0000_0008, 1, {32'h4, 32'h4});
      add(0, 0, 32'h0,         1, 32'h8,         1, 32'h0000_000C, 1, {32'h8, 32'h8});
      // back-pressure: word C goes to skid, HOLD ignores acks
      add(1, 0, 32'h0,         1, 32'hC,         0, 32'h0000_0010, 1, {32'h8, 32'h8});
      add(1, 0, 32'h0,         1, 32'hDEAD,      0, 32'h0000_0010, 1, {32'h8, 32'h8});
      add(1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0010, 1, {32'h8, 32'h8});
      add(0, 0, 32'h0,         1, 32'hBEEF,      1, 32'h0000_0010, 1, {32'hC, 32'hC});
      add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0010, 0, {32'hC, 32'hC});
      add(1, 0, 32'h0,         1, 32'h10,        1, 32'h0000_0014, 1, {32'h10, 32'h10});
      // redirect coinciding with ack
      add(0, 1, 32'h0000_0103, 1, 32'h14,        1, 32'h0000_0100, 0, {32'h10, 32'h10});
      add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0100, 0, {32'h10, 32'h10});
      // redirect while request outstanding -> DROP at old address
      add(0, 1, 32'h0000_0200, 0, 32'h0,         1, 32'h0000_0100, 0, {32'h10, 32'h10});
      add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0100, 0, {32'h10, 32'h10});
      add(0, 0, 32'h0,         1, 32'hABCD,      1, 32'h0000_0200, 0, {32'h10, 32'h10});
      add(0, 0, 32'h0,         1, 32'h55,        1, 32'h0000_0204, 1, {32'h200, 32'h55});
      // PC wrap at top of address space
      add(0, 1, 32'hFFFF_FFFF, 1, 32'h66,        1, 32'hFFFF_FFFC, 0, {32'h200, 32'h55});
      add(0, 0, 32'h0,         1, 32'h77,        1, 32'h0000_0000, 1, {32'hFFFF_FFFC, 32'h77});
      // redirect in HOLD discards the skid word
      add(1, 0, 32'h0,         1, 32'h88,        0, 32'h0000_0004, 1, {32'hFFFF_FFFC, 32'h77});
      add(1, 1, 32'h0000_0300, 0, 32'h0,         1, 32'h0000_0300, 0, {32'hFFFF_FFFC, 32'h77});
      add(1, 0, 32'h0,         1, 32'h99,        1, 32'h0000_0304, 1, {32'h300, 32'h99});
      // 3-cycle latency, redirect on first wait, retarget while in DROP
      add(0, 1, 32'h0000_0400, 0, 32'h0,         1, 32'h0000_0304, 0, {32'h300, 32'h99});
      add(0, 1, 32'h0000_0500, 0, 32'h0,         1, 32'h0000_0304, 0, {32'h300, 32'h99});
      add(0, 0, 32'h0,         1, 32'hEEEE,      1, 32'h0000_0500, 0, {32'h300, 32'h99});
      add(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0500, 0, {32'h300, 32'h99});

      reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      @(posedge clk); #1;
      chk_outs("reset", 1'b0, 32'h0, 1'b0, 64'h0);
      #2 reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         stall = vecs[i].stall; redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
         imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
         @(posedge clk); #1;
         chk_outs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                  vecs[i].exp_valid, vecs[i].exp_ifid);
      end

      // Reset with a request outstanding at 0x500; late ack arrives during reset.
      stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk_outs("async_rst", 1'b0, 32'h0, 1'b0, 64'h0);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      chk_outs("rst_ack", 1'b0, 32'h0, 1'b0, 64'h0);
      #2 reset = 1'b1; imem_rdata = 32'h0000_0000;
      @(posedge clk); #1;
      chk_outs("post_rst1", 1'b1, 32'h0, 1'b0, 64'h0);
      imem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      chk_outs("post_rst2", 1'b1, 32'h4, 1'b1, {32'h0, 32'h1234_5678});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of first fetch after reset.
REQ-002 Parameter PC_STEP, default 4, PC increment per accepted instruction.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset, 1 = run).
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  32  fetch address, equal to internal PC.
REQ-007 imem_ack  input  1  memory response valid, sampled on clk.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 stall  input  1  decode cannot accept a new IF/ID value this cycle.
REQ-010 redirect_valid  input  1  branch/jump target valid this cycle.
REQ-011 redirect_pc  input  32  redirect target address.
REQ-012 ifid_reg  output  64  IF/ID register: [31:0] instruction, [63:32] PC of that instruction.
REQ-013 ifid_valid  output  1  ifid_reg holds a live instruction.

Function
REQ-014 The block SHALL implement states IDLE, FETCH, HOLD, DROP; IDLE SHALL advance to FETCH unconditionally after one clk.
REQ-015 imem_req SHALL be 1 in FETCH and DROP, 0 in IDLE and HOLD; imem_addr SHALL equal PC and stay stable while imem_req=1 until imem_ack.
REQ-016 IF/ID "can accept" SHALL mean ifid_valid=0 or stall=0.
REQ-017 FETCH, imem_ack=1, redirect_valid=0, can accept: ifid_reg<={PC, imem_rdata}, ifid_valid<=1, PC<=PC+PC_STEP, remain FETCH (zero-wait memory yields one instruction per clk).
REQ-018 FETCH, imem_ack=1, redirect_valid=0, cannot accept: imem_rdata and PC SHALL be captured in a one-entry skid buffer, PC<=PC+PC_STEP, go HOLD; ifid_reg unchanged.
REQ-019 HOLD with stall=0: skid contents SHALL move to ifid_reg, ifid_valid<=1, go FETCH; HOLD with stall=1: all outputs held.
REQ-020 ifid_valid=1, stall=0, and no new instruction loaded that clk: ifid_valid<=0; ifid_reg data SHALL retain last value.
REQ-021 stall=1 with ifid_valid=1 SHALL hold ifid_reg and ifid_valid unchanged.
REQ-022 redirect_valid=1 SHALL take priority over every other event: ifid_valid<=0, skid discarded, PC<={redirect_pc[31:2],2'b00}.
REQ-023 Redirect in FETCH with imem_ack=0 (request outstanding): go DROP; DROP SHALL keep imem_req=1 at the old address until imem_ack, discard imem_rdata, then go FETCH at the redirected PC.
REQ-024 Redirect in FETCH coinciding with imem_ack=1: data discarded, remain FETCH, next imem_addr = redirect target.
REQ-025 Redirect in HOLD: go FETCH; redirect in DROP: update PC to newest target, stay DROP.
REQ-026 PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-027 imem_ack received in IDLE or HOLD SHALL be ignored.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, PC=RESET_PC, skid cleared, ifid_reg=0, ifid_valid=0, imem_req=0, imem_addr=RESET_PC.
REQ-029 Reset mid-transaction SHALL abandon the outstanding request; no stale response SHALL reach ifid_reg.
REQ-030 First ifid_valid=1 SHALL occur no earlier than the second rising clk after reset deasserts (zero-wait memory).

Verification
REQ-031 Zero-wait memory returning addr as data, no stall -> ifid_reg = {0,0},{4,4},{8,8} on consecutive clks, ifid_valid=1 continuously.
REQ-032 stall=1 for 3 clks while ifid_valid=1 -> ifid_reg frozen, one word captured in skid, imem_req=0 in HOLD; stall release -> skid word appears next clk, no loss/duplication.
REQ-033 redirect_valid=1, redirect_pc=32'h0000_0103, same clk as imem_ack -> ifid_valid=0 next clk, next imem_addr=32'h0000_0100.
REQ-034 Memory with 3-clk ack latency, redirect on 1st wait clk -> DROP until ack, that data discarded, next request at redirect target.
REQ-035 PC=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
REQ-036 reset asserted while a request is outstanding and ack arrives during reset -> ifid_valid=0, ifid_reg=0, first post-reset fetch at RESET_PC.
